clk_div_ctrl: RTL
=================

# clk_div_ctrl

Run/stop and reconfiguration controller for the encoder/decoder's slow-clock generation. It produces a divided clock whose half-period is programmable at run time through a valid/ready configuration port. New ratios are applied only at period boundaries, and stopping never truncates a high phase, so downstream logic never sees a glitch or runt pulse. A one-cycle tick aligned to each rising edge of the divided clock is provided for clock-enable style consumers.

## Interface
- CNT_W, 16, width of half-period counter and configuration value
- DEFAULT_HALF, 125, half-period (in clk_in cycles) after reset; legal range 1..2^CNT_W-1

- clk_in  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  level run request
- cfg_valid  input  1  configuration request
- cfg_half  input  CNT_W  requested half-period H
- cfg_ready  output  1  configuration slot free; transfer when cfg_valid && cfg_ready
- cfg_err  output  1  one-cycle pulse: accepted cfg_half was 0, discarded
- clk_out  output  1  divided clock, registered
- tick  output  1  one-cycle pulse, high in the same cycle clk_out first reads 1
- running  output  1  state != IDLE
- cur_half  output  CNT_W  half-period currently in effect

## Operation
- States:
  - IDLE: clk_out = 0, counter = 0.
  - RUN: dividing.
  - STOPPING: finishing the current high phase.
- Counter counts 0..cur_half-1. At cur_half-1 it wraps to 0 and clk_out toggles.
- Output period is 2*cur_half. Each period is a low phase followed by a high phase.
- Period boundary: the edge at which clk_out goes 1->0.
- IDLE -> RUN when en = 1. Counter = 0 and clk_out = 0 after that edge.
- RUN, en = 0, clk_out = 0: go to IDLE immediately. Counter clears; the output stays low, so there is no glitch.
- RUN, en = 0, clk_out = 1: go to STOPPING.
- STOPPING: the high phase completes normally. At the boundary, go to IDLE with clk_out = 0.
- STOPPING, en = 1 again: return to RUN without disturbing counter or clk_out.
- Configuration has a single pending slot:
  - In IDLE, an accepted value is written directly to cur_half at the accept edge. cfg_ready stays 1.
  - In RUN or STOPPING, an accepted value goes to the pending register and cfg_ready drops to 0.
  - The pending value is copied to cur_half at the next boundary, with the counter reset to 0. cfg_ready returns to 1 on that edge.
  - If the boundary is reached while the controller is returning to IDLE, the pending value is still applied.
- cfg_half = 0 is accepted, then discarded: cfg_err pulses, nothing is stored, cfg_ready is unaffected.
- tick is asserted on the edge that sets clk_out 0->1 and cleared on the next edge.

## Timing
- Reset values: clk_out 0, tick 0, cfg_ready 1, cfg_err 0, running 0, cur_half DEFAULT_HALF, pending empty, state IDLE.
- If en is sampled 1 in IDLE at edge k:
  - clk_out rises after edge k+H, with tick high for that cycle.
  - clk_out falls after edge k+2H, and repeats every 2H thereafter.
- H = 1: clk_out toggles every edge; tick fires every 2 cycles.
- A ratio change never produces a phase shorter than min(old H, new H). Both halves of the period after the boundary use the new H.
- A cfg accept on the same edge as a boundary, with the pending slot empty: the value is stored as pending and applied at the following boundary, not at the current one.
- cfg accept and en rising on the same edge in IDLE: the first period uses the new H.
- Reset asserted mid-operation: all outputs take their reset values asynchronously and the pending value is lost. Operation resumes from IDLE on the first edge after rst_n deasserts.
- running is registered: it rises one edge after en is sampled and falls on the edge entering IDLE.

## Test plan
- Reset, en = 1, default H = 125: clk_out period 250 cycles at 50% duty; tick every 250 cycles, coincident with each rising edge.
- Running with H = 4, write cfg_half = 2 mid-high-phase: cfg_ready low until the next falling edge; the phases before it are 4 long, every phase after it is 2; cur_half updates at the boundary.
- Running with H = 5, drop en 2 cycles into the high phase: the high phase still lasts 5, then IDLE with clk_out 0. Dropping en during the low phase instead gives an immediate IDLE with clk_out held at 0.
- STOPPING with en re-raised 1 cycle later: the waveform is identical to an uninterrupted run and running never drops.
- cfg_half = 0 in RUN and in IDLE: cfg_err is a 1-cycle pulse and cur_half is unchanged. H = 1: clk_out toggles every cycle.
- Assert rst_n low mid-high-phase with a pending config: clk_out 0, cfg_ready 1, cur_half = DEFAULT_HALF immediately; after release with en = 1, normal 250-cycle periods.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Run/stop and reconfiguration controller for a glitch-free programmable clock divider.
// Ratio changes land only on period boundaries; stopping never truncates a high phase.
module clk_div_ctrl #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 125
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             running,
  output logic [CNT_W-1:0] cur_half
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStopping
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic cfg_acc;
  logic cfg_zero;
  logic last;
  logic apply;

  assign cfg_acc  = cfg_valid && !pend_vld_q;
  assign cfg_zero = (cfg_half == '0);
  assign last     = (cnt_q == (half_q - CNT_W'(1)));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clk_d      = clk_q;
    half_d     = half_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    err_d      = 1'b0;
    apply      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        clk_d = 1'b0;
        if (en) begin
          state_d = StRun;
        end
      end
      StRun, StStopping: begin
        if (!en && !clk_q) begin
          // Low phase: stopping here cannot shorten a visible pulse.
          state_d = StIdle;
          cnt_d   = '0;
          apply   = 1'b1;
        end else begin
          if (last) begin
            cnt_d = '0;
            clk_d = ~clk_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (last && clk_q) begin
            apply   = 1'b1;
            state_d = en ? StRun : StIdle;
          end else begin
            state_d = en ? StRun : StStopping;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        clk_d   = 1'b0;
      end
    endcase

    // Pending ratio is consumed before a new accept so a same-edge accept waits a period.
    if (apply && pend_vld_q) begin
      half_d     = pend_q;
      pend_vld_d = 1'b0;
    end

    if (cfg_acc) begin
      if (cfg_zero) begin
        err_d = 1'b1;
      end else if (state_q == StIdle) begin
        half_d = cfg_half;
      end else begin
        pend_d     = cfg_half;
        pend_vld_d = 1'b1;
      end
    end

    tick_d = !clk_q && clk_d;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= CNT_W'(DEFAULT_HALF);
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      err_q      <= err_d;
    end
  end

  assign cfg_ready = !pend_vld_q;
  assign cfg_err   = err_q;
  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign running   = (state_q != StIdle);
  assign cur_half  = half_q;

endmodule
